// File: rtl/theta_diff_omega.sv
// theta_diff_omega: turns successive wrapped angle samples into an angular rate,
// omega = wrap(theta - theta_prev) * INV_DT, fully pipelined with a fixed 22-cycle latency.
`ifndef ENA_MATH
`define ENA_MATH 1'b1
`endif

// Double-precision add/subtract, round-to-nearest-even, subnormals flushed to zero, 7-cycle latency.
module ADD_SUB_64 (
    input  logic        clk,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic        add_sub,
    input  logic [63:0] dataa,
    input  logic [63:0] datab,
    output logic [63:0] result
);
    localparam int LAT = 7;

    function automatic int lzc56(input logic [55:0] v);
        int n;
        n = 56;
        for (int i = 0; i < 56; i++)
            if (v[i]) n = 55 - i;
        return n;
    endfunction

    // {1.52 mantissa, guard, round, sticky} -> {carry, 53-bit rounded mantissa}
    function automatic logic [53:0] rne56(input logic [55:0] m);
        logic up;
        up = m[2] & (m[1] | m[0] | m[3]);
        return {1'b0, m[55:3]} + {53'd0, up};
    endfunction

    logic               sb, sx, sy;
    logic [10:0]        ex, ey, ediff;
    logic [51:0]        fx, fy, frac;
    logic [52:0]        mx, my;
    logic [111:0]       wide;
    logic [55:0]        my_e, norm;
    logic [56:0]        sum;
    logic signed [12:0] exp_r;
    logic [53:0]        rnd;
    int                 sh;
    logic [63:0]        res_c;
    logic [63:0]        pipe [LAT];

    always_comb begin
        sb = datab[63] ^ ~add_sub;
        if (dataa[62:0] >= datab[62:0]) begin
            sx = dataa[63]; ex = dataa[62:52]; fx = dataa[51:0];
            sy = sb;        ey = datab[62:52]; fy = datab[51:0];
        end else begin
            sx = sb;        ex = datab[62:52]; fx = datab[51:0];
            sy = dataa[63]; ey = dataa[62:52]; fy = dataa[51:0];
        end
        mx = (ex != 11'd0) ? {1'b1, fx} : 53'd0;
        my = (ey != 11'd0) ? {1'b1, fy} : 53'd0;
        ediff = ex - ey;
        wide = {my, 59'd0} >> ediff;
        my_e = wide[111:56];
        my_e[0] = my_e[0] | (|wide[55:0]);
        if (ediff > 11'd111) my_e = {55'd0, |my};
        exp_r = $signed({2'b00, ex});
        sh = 0;
        if (sx == sy) begin
            sum = {1'b0, mx, 3'b000} + {1'b0, my_e};
            if (sum[56]) begin
                norm = {sum[56:2], sum[1] | sum[0]};
                exp_r = exp_r + 13'sd1;
            end else begin
                norm = sum[55:0];
            end
        end else begin
            sum = {1'b0, mx, 3'b000} - {1'b0, my_e};
            sh = lzc56(sum[55:0]);
            norm = sum[55:0] << sh;
            exp_r = exp_r - 13'(sh);
        end
        rnd = rne56(norm);
        if (rnd[53]) begin
            frac = rnd[52:1];
            exp_r = exp_r + 13'sd1;
        end else begin
            frac = rnd[51:0];
        end
        if (norm == 56'd0 || exp_r <= 13'sd0) res_c = 64'd0;
        else if (exp_r >= 13'sd2047)          res_c = {sx, 11'h7FF, 52'd0};
        else                                  res_c = {sx, exp_r[10:0], frac};
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (clk_en) begin
            pipe[0] <= res_c;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign result = pipe[LAT-1];
endmodule

// Double-precision multiply, round-to-nearest-even, subnormals flushed to zero, 6-cycle latency.
module multiplier_64_dsp (
    input  logic        clk,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic [63:0] dataa,
    input  logic [63:0] datab,
    output logic [63:0] result
);
    localparam int LAT = 6;

    function automatic logic [53:0] rne56(input logic [55:0] m);
        logic up;
        up = m[2] & (m[1] | m[0] | m[3]);
        return {1'b0, m[55:3]} + {53'd0, up};
    endfunction

    logic               zero_in;
    logic [52:0]        ma, mb;
    logic [105:0]       prod;
    logic [55:0]        norm;
    logic signed [12:0] exp_r;
    logic [53:0]        rnd;
    logic [51:0]        frac;
    logic [63:0]        res_c;
    logic [63:0]        pipe [LAT];

    always_comb begin
        zero_in = (dataa[62:52] == 11'd0) || (datab[62:52] == 11'd0);
        ma = {1'b1, dataa[51:0]};
        mb = {1'b1, datab[51:0]};
        prod = {53'd0, ma} * {53'd0, mb};
        exp_r = $signed({2'b00, dataa[62:52]}) + $signed({2'b00, datab[62:52]}) - 13'sd1023;
        if (prod[105]) begin
            norm = {prod[105:51], |prod[50:0]};
            exp_r = exp_r + 13'sd1;
        end else begin
            norm = {prod[104:50], |prod[49:0]};
        end
        rnd = rne56(norm);
        if (rnd[53]) begin
            frac = rnd[52:1];
            exp_r = exp_r + 13'sd1;
        end else begin
            frac = rnd[51:0];
        end
        if (zero_in || exp_r <= 13'sd0) res_c = 64'd0;
        else if (exp_r >= 13'sd2047)    res_c = {dataa[63] ^ datab[63], 11'h7FF, 52'd0};
        else                            res_c = {dataa[63] ^ datab[63], exp_r[10:0], frac};
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (clk_en) begin
            pipe[0] <= res_c;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign result = pipe[LAT-1];
endmodule

module theta_diff_omega #(
    parameter logic [63:0] INV_DT    = 64'h40D3880000000000,
    parameter logic [63:0] CONST_PI  = 64'h400921FB54442D18,
    parameter logic [63:0] CONST_2PI = 64'h401921FB54442D18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rst_user,
    input  logic        sta,
    input  logic [63:0] theta,
    output logic [63:0] omega,
    output logic        omega_valid,
    output logic        done_sig
);
    localparam int DEPTH = 22;

    logic              accept;
    logic              first_n;
    logic [63:0]       theta_prev;
    logic [DEPTH-2:0]  vld_dl, tag_dl;
    logic [63:0]       d_p1;
    logic [63:0]       d_m_pi_p2, d_p_pi_p2, d_m_2pi_p2, d_p_2pi_p2;
    logic [63:0]       d_dly [7];
    logic [63:0]       d_sel_p3;
    logic [63:0]       prod_p4;
    logic              gt_pi, le_npi;

    assign accept = sta & ~rst_user;

    // Stage 1: d = theta - theta_prev (pre-update value of theta_prev)
    ADD_SUB_64 u_sub (.clk(clk), .aclr(rst), .clk_en(`ENA_MATH), .add_sub(1'b0),
                      .dataa(theta), .datab(theta_prev), .result(d_p1));

    // Stage 2: range tests and both wrapped candidates in parallel
    ADD_SUB_64 u_m_pi  (.clk(clk), .aclr(rst), .clk_en(`ENA_MATH), .add_sub(1'b0),
                        .dataa(d_p1), .datab(CONST_PI),  .result(d_m_pi_p2));
    ADD_SUB_64 u_p_pi  (.clk(clk), .aclr(rst), .clk_en(`ENA_MATH), .add_sub(1'b1),
                        .dataa(d_p1), .datab(CONST_PI),  .result(d_p_pi_p2));
    ADD_SUB_64 u_m_2pi (.clk(clk), .aclr(rst), .clk_en(`ENA_MATH), .add_sub(1'b0),
                        .dataa(d_p1), .datab(CONST_2PI), .result(d_m_2pi_p2));
    ADD_SUB_64 u_p_2pi (.clk(clk), .aclr(rst), .clk_en(`ENA_MATH), .add_sub(1'b1),
                        .dataa(d_p1), .datab(CONST_2PI), .result(d_p_2pi_p2));

    // d > pi when d-pi is strictly positive; d <= -pi when d+pi is negative or any zero
    assign gt_pi  = ~d_m_pi_p2[63] & (|d_m_pi_p2[62:0]);
    assign le_npi = d_p_pi_p2[63] | ~(|d_p_pi_p2[62:0]);

    // Stage 3: select register
    always_ff @(posedge clk) begin
        d_dly[0] <= d_p1;
        for (int i = 1; i < 7; i++) d_dly[i] <= d_dly[i-1];
        if (gt_pi)       d_sel_p3 <= d_m_2pi_p2;
        else if (le_npi) d_sel_p3 <= d_p_2pi_p2;
        else             d_sel_p3 <= d_dly[6];
    end

    // Stage 4: scale by 1/delta_t
    multiplier_64_dsp u_mul (.clk(clk), .aclr(rst), .clk_en(`ENA_MATH),
                             .dataa(d_sel_p3), .datab(INV_DT), .result(prod_p4));

    // Stage 5: output register, gated by the sample/tag delay line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            theta_prev  <= '0;
            first_n     <= 1'b0;
            vld_dl      <= '0;
            tag_dl      <= '0;
            omega       <= '0;
            omega_valid <= 1'b0;
            done_sig    <= 1'b0;
        end else if (rst_user) begin
            theta_prev  <= '0;
            first_n     <= 1'b0;
            vld_dl      <= '0;
            tag_dl      <= '0;
            omega       <= '0;
            omega_valid <= 1'b0;
            done_sig    <= 1'b0;
        end else begin
            if (accept) begin
                theta_prev <= theta;
                first_n    <= 1'b1;
            end
            vld_dl   <= {vld_dl[DEPTH-3:0], accept};
            tag_dl   <= {tag_dl[DEPTH-3:0], first_n};
            done_sig <= vld_dl[DEPTH-2];
            if (vld_dl[DEPTH-2]) begin
                if (tag_dl[DEPTH-2]) begin
                    omega       <= prod_p4;
                    omega_valid <= 1'b1;
                end else begin
                    omega <= '0;
                end
            end
        end
    end
endmodule
